// File: rtl/irq_ctrl_prio_if.sv
// rtl/irq_ctrl_prio_if.sv - APB register bus bundle for irq_ctrl_prio
interface irq_ctrl_prio_if;
    logic        psel_i;
    logic        penable_i;
    logic        pwrite_i;
    logic [31:0] paddr_i;
    logic [31:0] pwdata_i;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        output prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/irq_ctrl_prio.sv
// rtl/irq_ctrl_prio.sv - N-source prioritised APB interrupt controller; IRQ_SYNC_EN adds input synchronizers
module irq_ctrl_prio #(
    parameter  int N_IRQ = 8,
    localparam int ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic                pclk_i,
    input  logic                rst_n_i,
    input  logic                enable_i,
    irq_ctrl_prio_if.slave      apb,
    input  logic [N_IRQ-1:0]    irq_trigger_i,
    output logic                interrupt_o,
    output logic [ID_W-1:0]     irq_id_o
);

    localparam logic [2:0] IDX_STATUS  = 3'd0;
    localparam logic [2:0] IDX_CLEAR   = 3'd1;
    localparam logic [2:0] IDX_MASK    = 3'd2;
    localparam logic [2:0] IDX_MODE    = 3'd3;
    localparam logic [2:0] IDX_PENDING = 3'd4;
    localparam logic [2:0] IDX_ID      = 3'd5;
    localparam logic [2:0] IDX_SET     = 3'd6;

    logic [N_IRQ-1:0] status;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] mode;
    logic [N_IRQ-1:0] irq_d;
    logic [N_IRQ-1:0] irq_s;
    logic [N_IRQ-1:0] ev;
    logic [N_IRQ-1:0] pend;
    logic [N_IRQ-1:0] wbits;
    logic [N_IRQ-1:0] clr_bits;
    logic [N_IRQ-1:0] set_bits;
    logic [ID_W-1:0]  id_next;
    logic [2:0]       idx;
    logic             wr;
    logic             rd;
    logic             access;
    logic             mapped;
    logic             reg_we;
    logic [31:0]      rdata;
    logic             unused_bits;

`ifdef IRQ_SYNC_EN
    logic [N_IRQ-1:0] sync_q1;
    logic [N_IRQ-1:0] sync_q2;

    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_trigger_i;
            sync_q2 <= sync_q1;
        end
    end

    assign irq_s = sync_q2;
`else
    assign irq_s = irq_trigger_i;
`endif

    function automatic logic [31:0] zext(input logic [N_IRQ-1:0] v);
        logic [31:0] r;
        r = '0;
        r[N_IRQ-1:0] = v;
        return r;
    endfunction

    assign wr     = apb.psel_i & apb.penable_i & apb.pwrite_i;
    assign rd     = apb.psel_i & ~apb.pwrite_i;
    assign access = apb.psel_i & apb.penable_i;
    assign idx    = apb.paddr_i[4:2];
    assign mapped = (apb.paddr_i[31:5] == 27'd0) && (idx != 3'd7);
    assign reg_we = wr & mapped;
    assign wbits  = apb.pwdata_i[N_IRQ-1:0];

    assign clr_bits = (reg_we && idx == IDX_CLEAR) ? wbits : '0;
    assign set_bits = (reg_we && idx == IDX_SET)   ? wbits : '0;

    assign ev   = (mode & irq_s & ~irq_d) | (~mode & irq_s);
    assign pend = status & mask;

    // Walk from the top so the lowest pending index is the one left standing.
    always_comb begin
        id_next = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) id_next = ID_W'(i);
        end
    end

    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            status      <= '0;
            mask        <= '0;
            mode        <= '0;
            irq_d       <= '0;
            interrupt_o <= 1'b0;
            irq_id_o    <= '0;
        end else begin
            irq_d       <= irq_s;
            status      <= (status & ~clr_bits) | (ev & {N_IRQ{enable_i}}) | set_bits;
            if (reg_we && idx == IDX_MASK) mask <= wbits;
            if (reg_we && idx == IDX_MODE) mode <= wbits;
            interrupt_o <= enable_i & (|pend);
            irq_id_o    <= enable_i ? id_next : '0;
        end
    end

    always_comb begin
        rdata = '0;
        if (rd && mapped) begin
            case (idx)
                IDX_STATUS:  rdata = zext(status);
                IDX_MASK:    rdata = zext(mask);
                IDX_MODE:    rdata = zext(mode);
                IDX_PENDING: rdata = zext(pend);
                IDX_ID: begin
                    rdata[31]       = interrupt_o;
                    rdata[ID_W-1:0] = irq_id_o;
                end
                default:     rdata = '0;
            endcase
        end
    end

    assign apb.prdata_o  = rdata;
    assign apb.pready_o  = 1'b1;
    assign apb.pslverr_o = access & ~mapped;

    assign unused_bits = ^{apb.paddr_i[1:0], apb.pwdata_i};

endmodule

// File: tb/tb_irq_ctrl_prio.sv
// tb/tb_irq_ctrl_prio.sv - directed self-checking bench for irq_ctrl_prio
module tb_irq_ctrl_prio;
    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] irq;
    logic       interrupt;
    logic [2:0] irq_id;
    int         checks;
    int         errors;
    logic [31:0] rdat;
    logic        rerr;

    irq_ctrl_prio_if bus ();

    irq_ctrl_prio #(.N_IRQ(8)) dut (
        .pclk_i        (clk),
        .rst_n_i       (rst_n),
        .enable_i      (enable),
        .apb           (bus.slave),
        .irq_trigger_i (irq),
        .interrupt_o   (interrupt),
        .irq_id_o      (irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
        @(negedge clk);
        bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b1;
        bus.paddr_i = a; bus.pwdata_i = d;
        @(negedge clk);
        bus.penable_i = 1'b1;
        #1 err = bus.pslverr_o;
        @(negedge clk);
        bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
        @(negedge clk);
        bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0; bus.paddr_i = a;
        @(negedge clk);
        bus.penable_i = 1'b1;
        #1 d = bus.prdata_o; err = bus.pslverr_o;
        bus.psel_i = 1'b0; bus.penable_i = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; enable = 1'b1; irq = '0;
        bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
        bus.paddr_i = '0; bus.pwdata_i = '0;
        #3;
        chk("reset_interrupt", {31'd0, interrupt}, 32'd0);
        chk("reset_id", {29'd0, irq_id}, 32'd0);
        chk("pready", {31'd0, bus.pready_o}, 32'd1);
        @(negedge clk); rst_n = 1'b1;

        // level pulse on irq[3]
        apb_write(32'h08, 32'h08, rerr);
        apb_write(32'h0C, 32'h00, rerr);
        @(negedge clk); irq = 8'h08;
        @(negedge clk); irq = 8'h00;
        chk("t1_int_after_k", {31'd0, interrupt}, 32'd0);
        @(negedge clk);
        chk("t1_int_after_k1", {31'd0, interrupt}, 32'd1);
        chk("t1_id", {29'd0, irq_id}, 32'd3);
        apb_read(32'h00, rdat, rerr);
        chk("t1_status", rdat, 32'h08);
        apb_write(32'h04, 32'h08, rerr);
        chk("t1_int_at_clear", {31'd0, interrupt}, 32'd1);
        @(negedge clk);
        chk("t1_int_cleared", {31'd0, interrupt}, 32'd0);

        // edge vs level with held input
        apb_write(32'h0C, 32'h01, rerr);
        apb_write(32'h08, 32'h01, rerr);
        @(negedge clk); irq = 8'h01;
        repeat (5) @(negedge clk);
        apb_write(32'h04, 32'h01, rerr);
        apb_read(32'h00, rdat, rerr);
        chk("t2_edge_status", rdat, 32'h00);
        chk("t2_edge_int", {31'd0, interrupt}, 32'd0);
        irq = 8'h00;
        apb_write(32'h0C, 32'h00, rerr);
        irq = 8'h01;
        repeat (2) @(negedge clk);
        apb_write(32'h04, 32'h01, rerr);
        apb_read(32'h00, rdat, rerr);
        chk("t2_level_status", rdat, 32'h01);
        irq = 8'h00;
        apb_write(32'h04, 32'h01, rerr);
        apb_read(32'h00, rdat, rerr);
        chk("t2_level_cleared", rdat, 32'h00);

        // priority
        apb_write(32'h08, 32'hFF, rerr);
        @(negedge clk); irq = 8'h50;
        @(negedge clk); irq = 8'h00;
        @(negedge clk);
        chk("t3_id4", {29'd0, irq_id}, 32'd4);
        chk("t3_int", {31'd0, interrupt}, 32'd1);
        apb_read(32'h14, rdat, rerr);
        chk("t3_id_reg", rdat, 32'h8000_0004);
        apb_write(32'h04, 32'h10, rerr);
        @(negedge clk);
        chk("t3_id6", {29'd0, irq_id}, 32'd6);
        apb_write(32'h04, 32'h40, rerr);

        // clear vs simultaneous rising edge
        apb_write(32'h0C, 32'h01, rerr);
        apb_write(32'h08, 32'h01, rerr);
        apb_write(32'h18, 32'h01, rerr);
        @(negedge clk);
        bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b1;
        bus.paddr_i = 32'h04; bus.pwdata_i = 32'h01;
        @(negedge clk);
        bus.penable_i = 1'b1; irq = 8'h01;
        @(negedge clk);
        bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
        apb_read(32'h00, rdat, rerr);
        chk("t4_status_kept", rdat, 32'h01);
        apb_write(32'h04, 32'h01, rerr);
        apb_read(32'h00, rdat, rerr);
        chk("t4_status_cleared", rdat, 32'h00);
        irq = 8'h00;
        apb_read(32'h04, rdat, rerr);
        chk("t4_clear_reads0", rdat, 32'h00);

        // unmapped access, SET with mask off
        apb_read(32'h1C, rdat, rerr);
        chk("t5_rd_slverr", {31'd0, rerr}, 32'd1);
        chk("t5_rd_data", rdat, 32'h00);
        apb_write(32'h40, 32'hFFFF_FFFF, rerr);
        chk("t5_wr_slverr", {31'd0, rerr}, 32'd1);
        apb_read(32'h08, rdat, rerr);
        chk("t5_mask_kept", rdat, 32'h01);
        chk("t5_mapped_ok", {31'd0, rerr}, 32'd0);
        apb_write(32'h08, 32'h00, rerr);
        apb_write(32'h18, 32'h02, rerr);
        apb_read(32'h00, rdat, rerr);
        chk("t5_status_set", rdat, 32'h02);
        apb_read(32'h10, rdat, rerr);
        chk("t5_pending", rdat, 32'h00);
        chk("t5_int", {31'd0, interrupt}, 32'd0);

        // disable, then async reset
        enable = 1'b0; irq = 8'hFF;
        repeat (3) @(negedge clk);
        apb_read(32'h00, rdat, rerr);
        chk("t6_status_frozen", rdat, 32'h02);
        apb_write(32'h08, 32'h02, rerr);
        @(negedge clk);
        chk("t6_int_disabled", {31'd0, interrupt}, 32'd0);
        irq = 8'h00;
        @(negedge clk); enable = 1'b1;
        @(negedge clk);
        chk("t6_int_enabled", {31'd0, interrupt}, 32'd1);
        chk("t6_id1", {29'd0, irq_id}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_int", {31'd0, interrupt}, 32'd0);
        chk("t6_rst_id", {29'd0, irq_id}, 32'd0);
        bus.psel_i = 1'b1; bus.pwrite_i = 1'b0; bus.paddr_i = 32'h00;
        #1 chk("t6_rst_status", bus.prdata_o, 32'h00);
        bus.paddr_i = 32'h08;
        #1 chk("t6_rst_mask", bus.prdata_o, 32'h00);
        bus.paddr_i = 32'h0C;
        #1 chk("t6_rst_mode", bus.prdata_o, 32'h00);
        bus.psel_i = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
